// File: rtl/soc_system_pio_pkg.sv
// Shared register map and edge-polarity encodings for the HPS input PIO blocks.
package soc_system_pio_pkg;

    typedef enum logic [1:0] {
        PIO_ADDR_DATA    = 2'd0,
        PIO_ADDR_RSVD    = 2'd1,
        PIO_ADDR_IRQMASK = 2'd2,
        PIO_ADDR_EDGECAP = 2'd3
    } pio_addr_e;

    localparam int unsigned EDGE_ANY  = 0;
    localparam int unsigned EDGE_RISE = 1;
    localparam int unsigned EDGE_FALL = 2;

endpackage

// File: rtl/soc_system_pio_bit_filter.sv
// One input bit: synchroniser chain followed by an optional stable-count debouncer.
module soc_system_pio_bit_filter #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic filt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s_out = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign filt = s_out;
        end else begin : g_debounce
            localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          filt_q;

            // Counter only runs while the synchronised input disagrees with the accepted value.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt    <= '0;
                    filt_q <= 1'b0;
                end else if (s_out == filt_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    filt_q <= s_out;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign filt = filt_q;
        end
    endgenerate

endmodule

// File: rtl/soc_system_hps_pio_in_irq.sv
// Avalon-MM input PIO: filtered inputs, sticky edge capture and a maskable level IRQ.
module soc_system_hps_pio_in_irq
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned BIT_CLEAR_MODE  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clear_vec;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [31:0]      rd_next;
    logic             wr;
    logic             unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        soc_system_pio_bit_filter #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_filter (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[i]),
            .filt   (filt[i])
        );
    end

    always_comb begin
        edges = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edges = filt & ~prev;
            EDGE_FALL: edges = ~filt & prev;
            default:   edges = filt ^ prev;
        endcase
    end

    always_comb begin
        clear_vec = '0;
        if (wr && address == PIO_ADDR_EDGECAP) begin
            clear_vec = (BIT_CLEAR_MODE != 0) ? writedata[WIDTH-1:0] : '1;
        end
    end

    always_comb begin
        rd_next = '0;
        case (pio_addr_e'(address))
            PIO_ADDR_DATA:    rd_next[WIDTH-1:0] = filt;
            PIO_ADDR_IRQMASK: rd_next[WIDTH-1:0] = irq_mask;
            PIO_ADDR_EDGECAP: rd_next[WIDTH-1:0] = edge_capture;
            PIO_ADDR_RSVD:    rd_next = '0;
        endcase
    end

    // New edges are OR-ed in after the clear so a coincident write cannot lose an event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
        end else begin
            prev         <= filt;
            edge_capture <= edges | (edge_capture & ~clear_vec);
            readdata     <= rd_next;
            if (wr && address == PIO_ADDR_IRQMASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
